frontend_cmd_issuer: RTL and testbench

Frontend-side issuer for the backend command interface. It accepts user read/write requests, then drives frontend commands to the backend controller with a valid/ready handshake. It supplies write data when the backend pulls it (ren) and collects returned read data into a response buffer, asserting stall back to the backend as that buffer fills. It sits between the frontend scheduler queue and the backend controller.

---
 rtl/frontend_command_definition_pkg.sv | 26 ++
 rtl/issuer_sync_fifo.sv | 55 +++++
 rtl/frontend_cmd_issuer.sv | 154 +++++++++++++++
 tb/tb_frontend_cmd_issuer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_command_definition_pkg.sv
// Shared command definitions between the frontend issuer and the backend controller.
// The command is packed as {op_type, row_addr, col_addr}.
package frontend_command_definition_pkg;

    localparam int CMD_ROW_W = 14;
    localparam int CMD_COL_W = 10;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_type_e;

    typedef struct packed {
        op_type_e               op_type;
        logic [CMD_ROW_W-1:0]   row_addr;
        logic [CMD_COL_W-1:0]   col_addr;
    } frontend_command_t;

    localparam int FRONTEND_CMD_BITS = $bits(frontend_command_t);

    typedef enum logic {
        SLOT_EMPTY   = 1'b0,
        SLOT_PENDING = 1'b1
    } slot_state_e;

endpackage

// File: rtl/issuer_sync_fifo.sv
// Show-ahead synchronous FIFO. Pop on empty is ignored; a push while full is
// dropped unless a pop frees the slot in the same cycle.
module issuer_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    // Empty reads as zero so the output never exposes stale entries.
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/frontend_cmd_issuer.sv
// Issues user read/write requests as frontend commands to the backend, feeds
// write data on ren and buffers returned read data with credit-based flow control.
module frontend_cmd_issuer
    import frontend_command_definition_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int ROW_W    = CMD_ROW_W,
    parameter int COL_W    = CMD_COL_W,
    parameter int WD_DEPTH = 4,
    parameter int RD_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         power_on_rst_n,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic                         i_req_op,
    input  logic [ROW_W-1:0]             i_req_row,
    input  logic [COL_W-1:0]             i_req_col,
    input  logic [DATA_W-1:0]            i_req_wdata,
    output logic                         o_frontend_command_valid,
    output logic [FRONTEND_CMD_BITS-1:0] o_frontend_command,
    input  logic                         i_backend_controller_ready,
    input  logic                         i_backend_controller_ren,
    output logic [DATA_W-1:0]            o_frontend_write_data,
    input  logic                         i_backend_read_data_valid,
    input  logic [DATA_W-1:0]            i_backend_read_data,
    output logic                         o_backend_controller_stall,
    output logic                         o_frontend_controller_ready,
    output logic                         o_rsp_valid,
    input  logic                         i_rsp_ready,
    output logic [DATA_W-1:0]            o_rsp_data,
    output logic [1:0]                   o_err
);

    localparam int CW  = $clog2(RD_DEPTH) + 1;
    localparam int RCW = $clog2(RD_DEPTH) + 1;
    localparam int WCW = $clog2(WD_DEPTH) + 1;

    slot_state_e       r_state;
    frontend_command_t r_cmd;
    logic [CW-1:0]     r_credits;
    logic              r_stall;
    logic [1:0]        r_err;

    frontend_command_t w_new_cmd;
    logic              w_xfer;
    logic              w_is_wr;
    logic              w_op_ok;
    logic              w_accept;
    logic              w_wd_push;
    logic              w_rd_accept;
    logic              w_rsp_pop;
    logic              w_wd_full;
    logic              w_wd_empty;
    logic [WCW-1:0]    w_wd_count_unused;
    logic              w_rd_full;
    logic              w_rd_empty;
    logic [RCW-1:0]    w_rd_count;
    logic              w_rd_push_ok;
    logic [RCW-1:0]    w_rd_cnt_nxt;

    assign w_is_wr  = (i_req_op == OP_WRITE);
    assign w_xfer   = (r_state == SLOT_PENDING) & i_backend_controller_ready;
    assign w_op_ok  = w_is_wr ? ~w_wd_full : (r_credits < CW'(RD_DEPTH));
    assign o_req_ready = ((r_state == SLOT_EMPTY) | w_xfer) & w_op_ok;

    assign w_accept    = i_req_valid & o_req_ready;
    assign w_wd_push   = w_accept & w_is_wr;
    assign w_rd_accept = w_accept & ~w_is_wr;
    assign w_rsp_pop   = o_rsp_valid & i_rsp_ready;

    always_comb begin
        w_new_cmd          = '0;
        w_new_cmd.op_type  = op_type_e'(i_req_op);
        w_new_cmd.row_addr = CMD_ROW_W'(i_req_row);
        w_new_cmd.col_addr = CMD_COL_W'(i_req_col);
    end

    issuer_sync_fifo #(.DEPTH(WD_DEPTH), .WIDTH(DATA_W)) u_wd_fifo (
        .clk     (clk),
        .rst_n   (power_on_rst_n),
        .i_push  (w_wd_push),
        .i_data  (i_req_wdata),
        .i_pop   (i_backend_controller_ren),
        .o_data  (o_frontend_write_data),
        .o_full  (w_wd_full),
        .o_empty (w_wd_empty),
        .o_count (w_wd_count_unused)
    );

    issuer_sync_fifo #(.DEPTH(RD_DEPTH), .WIDTH(DATA_W)) u_rd_fifo (
        .clk     (clk),
        .rst_n   (power_on_rst_n),
        .i_push  (i_backend_read_data_valid),
        .i_data  (i_backend_read_data),
        .i_pop   (w_rsp_pop),
        .o_data  (o_rsp_data),
        .o_full  (w_rd_full),
        .o_empty (w_rd_empty),
        .o_count (w_rd_count)
    );

    assign o_rsp_valid                 = ~w_rd_empty;
    assign o_frontend_controller_ready = ~w_rd_full;
    assign o_frontend_command_valid    = (r_state == SLOT_PENDING);
    assign o_frontend_command          = r_cmd;
    assign o_backend_controller_stall  = r_stall;
    assign o_err                       = r_err;

    // Occupancy after this edge, mirroring the FIFO's own accept rules.
    assign w_rd_push_ok = i_backend_read_data_valid & (~w_rd_full | w_rsp_pop);
    assign w_rd_cnt_nxt = w_rd_count + RCW'(w_rd_push_ok) - RCW'(w_rsp_pop);

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_state <= SLOT_EMPTY;
            r_cmd   <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (w_accept) begin
                        r_state <= SLOT_PENDING;
                        r_cmd   <= w_new_cmd;
                    end
                end
                SLOT_PENDING: begin
                    if (w_xfer) begin
                        if (w_accept) r_cmd   <= w_new_cmd;
                        else          r_state <= SLOT_EMPTY;
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_credits <= '0;
            r_stall   <= 1'b0;
            r_err     <= 2'b00;
        end else begin
            unique case ({w_rd_accept, w_rsp_pop})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
            r_stall <= (w_rd_cnt_nxt >= RCW'(RD_DEPTH - 1));
            if (i_backend_controller_ren & w_wd_empty) r_err[0] <= 1'b1;
            if (i_backend_read_data_valid & w_rd_full & ~w_rsp_pop) r_err[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frontend_cmd_issuer.sv
// Directed bench for frontend_cmd_issuer: vector tables for the steady-state
// flows plus hand-written sequences for credits, overflow, underflow and reset.
module tb_frontend_cmd_issuer;
    import frontend_command_definition_pkg::*;

    logic                         clk = 1'b0;
    logic                         power_on_rst_n;
    logic                         i_req_valid, o_req_ready, i_req_op;
    logic [13:0]                  i_req_row;
    logic [9:0]                   i_req_col;
    logic [127:0]                 i_req_wdata;
    logic                         o_frontend_command_valid;
    logic [FRONTEND_CMD_BITS-1:0] o_frontend_command;
    logic                         i_backend_controller_ready, i_backend_controller_ren;
    logic [127:0]                 o_frontend_write_data;
    logic                         i_backend_read_data_valid;
    logic [127:0]                 i_backend_read_data;
    logic                         o_backend_controller_stall, o_frontend_controller_ready;
    logic                         o_rsp_valid, i_rsp_ready;
    logic [127:0]                 o_rsp_data;
    logic [1:0]                   o_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frontend_cmd_issuer dut (
        .clk                         (clk),
        .power_on_rst_n              (power_on_rst_n),
        .i_req_valid                 (i_req_valid),
        .o_req_ready                 (o_req_ready),
        .i_req_op                    (i_req_op),
        .i_req_row                   (i_req_row),
        .i_req_col                   (i_req_col),
        .i_req_wdata                 (i_req_wdata),
        .o_frontend_command_valid    (o_frontend_command_valid),
        .o_frontend_command          (o_frontend_command),
        .i_backend_controller_ready  (i_backend_controller_ready),
        .i_backend_controller_ren    (i_backend_controller_ren),
        .o_frontend_write_data       (o_frontend_write_data),
        .i_backend_read_data_valid   (i_backend_read_data_valid),
        .i_backend_read_data         (i_backend_read_data),
        .o_backend_controller_stall  (o_backend_controller_stall),
        .o_frontend_controller_ready (o_frontend_controller_ready),
        .o_rsp_valid                 (o_rsp_valid),
        .i_rsp_ready                 (i_rsp_ready),
        .o_rsp_data                  (o_rsp_data),
        .o_err                       (o_err)
    );

    typedef struct {
        logic rv; logic op; logic [13:0] row; logic [9:0] col; logic [127:0] wd;
        logic br; logic ren; logic rdv; logic [127:0] rd; logic rspr;
        logic e_rdy; logic e_cv; logic [24:0] e_cmd; logic [127:0] e_wd;
        logic e_rspv; logic [127:0] e_rsp; logic e_stall; logic e_fcr; logic [1:0] e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [24:0] cmdv(input logic op, input logic [13:0] r, input logic [9:0] c);
        return {op, r, c};
    endfunction

    function automatic logic [127:0] bt(input int k);
        return 128'hB000 + 128'(k);
    endfunction

    function automatic vec_t mk(
        input logic rv, input logic op, input logic [13:0] row, input logic [9:0] col,
        input logic [127:0] wd, input logic br, input logic ren, input logic rdv,
        input logic [127:0] rd, input logic rspr, input logic e_rdy, input logic e_cv,
        input logic [24:0] e_cmd, input logic [127:0] e_wd, input logic e_rspv,
        input logic [127:0] e_rsp, input logic e_stall, input logic e_fcr, input logic [1:0] e_err);
        vec_t v;
        v.rv = rv; v.op = op; v.row = row; v.col = col; v.wd = wd;
        v.br = br; v.ren = ren; v.rdv = rdv; v.rd = rd; v.rspr = rspr;
        v.e_rdy = e_rdy; v.e_cv = e_cv; v.e_cmd = e_cmd; v.e_wd = e_wd;
        v.e_rspv = e_rspv; v.e_rsp = e_rsp; v.e_stall = e_stall; v.e_fcr = e_fcr; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        i_req_valid = 0; i_req_op = 0; i_req_row = '0; i_req_col = '0; i_req_wdata = '0;
        i_backend_controller_ready = 1; i_backend_controller_ren = 0;
        i_backend_read_data_valid = 0; i_backend_read_data = '0; i_rsp_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        i_req_valid = v.rv; i_req_op = v.op; i_req_row = v.row; i_req_col = v.col;
        i_req_wdata = v.wd; i_backend_controller_ready = v.br; i_backend_controller_ren = v.ren;
        i_backend_read_data_valid = v.rdv; i_backend_read_data = v.rd; i_rsp_ready = v.rspr;
        #1 chk($sformatf("v%0d.req_ready", idx), 128'(o_req_ready), 128'(v.e_rdy));
        tick();
        chk($sformatf("v%0d.cmd_valid", idx), 128'(o_frontend_command_valid), 128'(v.e_cv));
        if (v.e_cv) chk($sformatf("v%0d.cmd", idx), 128'(o_frontend_command), 128'(v.e_cmd));
        chk($sformatf("v%0d.wdata", idx), o_frontend_write_data, v.e_wd);
        chk($sformatf("v%0d.rsp_valid", idx), 128'(o_rsp_valid), 128'(v.e_rspv));
        chk($sformatf("v%0d.rsp_data", idx), o_rsp_data, v.e_rsp);
        chk($sformatf("v%0d.stall", idx), 128'(o_backend_controller_stall), 128'(v.e_stall));
        chk($sformatf("v%0d.fc_ready", idx), 128'(o_frontend_controller_ready), 128'(v.e_fcr));
        chk($sformatf("v%0d.err", idx), 128'(o_err), 128'(v.e_err));
    endtask

    initial begin
        logic [127:0] A, D1, D3, R1, R2, Z, P1, P2;
        logic [24:0]  WC;
        A  = {16{8'hA5}};
        D1 = 128'h1111; D3 = 128'h3333; R1 = 128'hAAAA_0001; R2 = 128'hAAAA_0002;
        Z  = 128'h5A5A; P1 = 128'hC001; P2 = 128'hC002;
        WC = cmdv(1'b1, 14'h123, 10'h010);

        // Write held off by the backend for 3 cycles, then popped by ren.
        tbl.push_back(mk(1,1,14'h123,10'h010,A, 0,0,0,'0,0, 1,1,WC,A, 0,'0,0,1,2'b00));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,'0,'0,'0, 0,0,0,'0,0, 0,1,WC,A, 0,'0,0,1,2'b00));
        tbl.push_back(mk(0,1,'0,'0,'0, 1,0,0,'0,0, 1,0,WC,A, 0,'0,0,1,2'b00));
        tbl.push_back(mk(0,1,'0,'0,'0, 0,1,0,'0,0, 1,0,'0,'0, 0,'0,0,1,2'b00));
        // Alternating W/R/W/R with backend always ready, then drain both sides.
        tbl.push_back(mk(1,1,14'd1,10'd1,D1, 1,0,0,'0,0, 1,1,cmdv(1,14'd1,10'd1),D1, 0,'0,0,1,2'b00));
        tbl.push_back(mk(1,0,14'd2,10'd2,'0, 1,0,0,'0,0, 1,1,cmdv(0,14'd2,10'd2),D1, 0,'0,0,1,2'b00));
        tbl.push_back(mk(1,1,14'd3,10'd3,D3, 1,0,0,'0,0, 1,1,cmdv(1,14'd3,10'd3),D1, 0,'0,0,1,2'b00));
        tbl.push_back(mk(1,0,14'd4,10'd4,'0, 1,0,0,'0,0, 1,1,cmdv(0,14'd4,10'd4),D1, 0,'0,0,1,2'b00));
        tbl.push_back(mk(0,0,'0,'0,'0, 1,0,0,'0,0, 1,0,'0,D1, 0,'0,0,1,2'b00));
        tbl.push_back(mk(0,0,'0,'0,'0, 1,1,0,'0,0, 1,0,'0,D3, 0,'0,0,1,2'b00));
        tbl.push_back(mk(0,0,'0,'0,'0, 1,1,0,'0,0, 1,0,'0,'0, 0,'0,0,1,2'b00));
        tbl.push_back(mk(0,0,'0,'0,'0, 1,0,1,R1,0, 1,0,'0,'0, 1,R1,0,1,2'b00));
        tbl.push_back(mk(0,0,'0,'0,'0, 1,0,1,R2,0, 1,0,'0,'0, 1,R1,0,1,2'b00));
        tbl.push_back(mk(0,0,'0,'0,'0, 1,0,0,'0,1, 1,0,'0,'0, 1,R2,0,1,2'b00));
        tbl.push_back(mk(0,0,'0,'0,'0, 1,0,0,'0,1, 1,0,'0,'0, 0,'0,0,1,2'b00));

        idle();
        power_on_rst_n = 0;
        #1;
        chk("rst.cmd_valid", 128'(o_frontend_command_valid), 128'(0));
        chk("rst.cmd", 128'(o_frontend_command), 128'(0));
        chk("rst.rsp_valid", 128'(o_rsp_valid), 128'(0));
        chk("rst.stall", 128'(o_backend_controller_stall), 128'(0));
        chk("rst.fc_ready", 128'(o_frontend_controller_ready), 128'(1));
        chk("rst.err", 128'(o_err), 128'(0));
        chk("rst.wdata", o_frontend_write_data, '0);
        chk("rst.req_ready", 128'(o_req_ready), 128'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        power_on_rst_n = 1;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Read credits: 4 reads issue, 5th blocked until a response is popped.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle();
            i_req_valid = 1; i_req_op = 0; i_req_row = 14'(i); i_req_col = 10'(i);
            #1 chk($sformatf("rd%0d.req_ready", i), 128'(o_req_ready), 128'(1));
            tick();
            chk($sformatf("rd%0d.cmd_valid", i), 128'(o_frontend_command_valid), 128'(1));
            chk($sformatf("rd%0d.cmd", i), 128'(o_frontend_command), 128'(cmdv(0, 14'(i), 10'(i))));
        end
        @(negedge clk); idle();
        i_req_valid = 1; i_req_op = 0; i_req_row = 14'd4; i_req_col = 10'd4;
        #1 chk("rd4.blocked", 128'(o_req_ready), 128'(0));
        tick();
        chk("rd4.cmd_valid", 128'(o_frontend_command_valid), 128'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle();
            i_backend_read_data_valid = 1; i_backend_read_data = bt(k);
            tick();
            chk($sformatf("ret%0d.stall", k), 128'(o_backend_controller_stall), 128'(k == 2));
            chk($sformatf("ret%0d.head", k), o_rsp_data, bt(0));
        end
        @(negedge clk); idle();
        i_req_valid = 1; i_req_op = 0; i_rsp_ready = 1;
        #1 chk("pop.still_blocked", 128'(o_req_ready), 128'(0));
        tick();
        chk("pop.head", o_rsp_data, bt(1));
        chk("pop.stall", 128'(o_backend_controller_stall), 128'(0));
        @(negedge clk); idle();
        i_req_valid = 1; i_req_op = 0; i_req_row = 14'd5; i_req_col = 10'd5;
        #1 chk("rd5.req_ready", 128'(o_req_ready), 128'(1));
        tick();
        chk("rd5.cmd", 128'(o_frontend_command), 128'(cmdv(0, 14'd5, 10'd5)));

        // Fill the read FIFO, then overflow it.
        for (int k = 3; k < 5; k++) begin
            @(negedge clk); idle();
            i_backend_read_data_valid = 1; i_backend_read_data = bt(k);
            tick();
        end
        chk("full.fc_ready", 128'(o_frontend_controller_ready), 128'(0));
        chk("full.stall", 128'(o_backend_controller_stall), 128'(1));
        @(negedge clk); idle();
        i_backend_read_data_valid = 1; i_backend_read_data = bt(5);
        tick();
        chk("ovf.err", 128'(o_err), 128'(2'b10));
        chk("ovf.head", o_rsp_data, bt(1));
        for (int k = 1; k < 5; k++) begin
            @(negedge clk); idle();
            i_rsp_ready = 1;
            #1 chk($sformatf("drain%0d.head", k), o_rsp_data, bt(k));
            tick();
        end
        chk("drain.rsp_valid", 128'(o_rsp_valid), 128'(0));

        // ren on empty wdata FIFO in the same cycle as a write accept.
        @(negedge clk); idle();
        i_req_valid = 1; i_req_op = 1; i_req_row = 14'd7; i_req_col = 10'd7;
        i_req_wdata = Z; i_backend_controller_ren = 1;
        #1 chk("unf.req_ready", 128'(o_req_ready), 128'(1));
        tick();
        chk("unf.err", 128'(o_err), 128'(2'b11));
        chk("unf.wdata", o_frontend_write_data, Z);
        chk("unf.cmd_valid", 128'(o_frontend_command_valid), 128'(1));
        @(negedge clk); idle();
        i_backend_controller_ren = 1;
        tick();
        chk("unf.pop_wdata", o_frontend_write_data, '0);

        // Reset while a command is pending with 2 write beats queued.
        @(negedge clk); idle();
        i_req_valid = 1; i_req_op = 1; i_req_wdata = P1; i_backend_controller_ready = 0;
        tick();
        @(negedge clk); idle();
        i_req_valid = 1; i_req_op = 1; i_req_wdata = P2;
        #1 chk("mid.req_ready", 128'(o_req_ready), 128'(1));
        tick();
        chk("mid.cmd_valid", 128'(o_frontend_command_valid), 128'(1));
        chk("mid.wdata", o_frontend_write_data, P1);
        @(negedge clk); idle();
        i_backend_controller_ready = 0;
        #1 power_on_rst_n = 0;
        #1;
        chk("mrst.cmd_valid", 128'(o_frontend_command_valid), 128'(0));
        chk("mrst.wdata", o_frontend_write_data, '0);
        chk("mrst.err", 128'(o_err), 128'(0));
        chk("mrst.rsp_valid", 128'(o_rsp_valid), 128'(0));
        @(negedge clk);
        power_on_rst_n = 1; i_req_op = 1;
        #1 chk("mrst.req_ready", 128'(o_req_ready), 128'(1));
        tick();
        chk("mrst.cmd_valid2", 128'(o_frontend_command_valid), 128'(0));
        chk("mrst.wdata2", o_frontend_write_data, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
